if_stage_pc: RTL and testbench
==============================

Name: if_stage_pc

Overview:
Instruction-fetch stage that sits directly upstream of the instruction ROM. It holds the program counter and drives the ROM address. It captures the returned instruction, together with PC+4, into the IF/ID pipeline register for the decode stage. It also handles stall, flush and branch/jump redirects from downstream stages.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
PC_STEP, 4, byte increment for sequential fetch. The PC is a byte address and is always word-aligned.

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard stall from decode; freezes the PC and the IF/ID register
flush  input  1  forces a bubble into the IF/ID register
branch_taken  input  1  redirect to branch_target
branch_target  input  32  byte address of the taken branch
jump  input  1  redirect to the J-type target
jump_index  input  26  instr_index field of the J-type instruction
inst_addr  output  32  address to the instruction ROM; equals the PC
inst_in  input  32  instruction word from the ROM, combinational from inst_addr
if_id_inst  output  32  registered instruction to decode
if_id_pc_plus4  output  32  registered PC+PC_STEP of the instruction in if_id_inst
if_id_valid  output  1  1 = if_id_inst is a real fetched instruction; 0 = bubble

Behaviour:
- inst_addr = pc, combinational. The ROM returns inst_in in the same cycle, and it is sampled on the next rising edge.
- Reset (rst=1 at a clock edge):
  - pc <= RESET_PC
  - if_id_inst <= 32'h0000_0000 (NOP)
  - if_id_pc_plus4 <= 0
  - if_id_valid <= 0
  - Reset overrides every other input, including mid-stall and mid-redirect.
- Jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
- Branch target = {branch_target[31:2], 2'b00}; low bits are silently forced to zero.
- Next-PC priority, highest first:
  1. rst
  2. jump
  3. branch_taken
  4. stall (hold pc)
  5. sequential: pc + PC_STEP, modulo 2^32, so 32'hFFFF_FFFC wraps to 0
- jump and branch_taken both asserted: jump wins.
- A redirect beats stall, because it comes from a later stage.
- IF/ID register update priority, highest first:
  1. rst
  2. redirect (jump or branch_taken) or flush: if_id_inst <= 0, if_id_valid <= 0, if_id_pc_plus4 <= 0
  3. stall: hold all three IF/ID fields
  4. otherwise: if_id_inst <= inst_in, if_id_pc_plus4 <= pc + PC_STEP, if_id_valid <= 1
- flush without a redirect only bubbles IF/ID. The PC still advances sequentially, or holds if stall=1.
- flush and stall together: IF/ID is bubbled, PC holds.
- Latency:
  - Instruction at address A appears on if_id_inst one cycle after inst_addr = A, when not stalled.
  - After a redirect, the first target instruction reaches IF/ID two edges later, with exactly one bubble cycle.
- No internal state machine beyond the PC and IF/ID registers. Every output is driven directly from registers, except inst_addr, which mirrors the pc register.

Test Plan:
1. Reset, then sequential fetch: after rst=1 for 1 cycle, drive inst_in = f(addr) from a ROM model. Required: inst_addr runs 0, 4, 8, 12; if_id_inst one cycle behind; if_id_pc_plus4 = 4, 8, 12; if_id_valid rises 1 cycle after reset is released.
2. Stall: assert stall for 2 cycles at pc=8. Required: inst_addr stays 8 and if_id holds the instruction from addr 4 with pc_plus4=8; fetch resumes at 12 afterwards.
3. Branch: branch_taken=1, branch_target=32'h0000_0041 while pc=16. Required: next inst_addr=32'h40; if_id_valid=0 for one cycle; then if_id_inst = ROM[0x40] with pc_plus4=0x44.
4. Jump vs branch: jump=1, jump_index=26'h000_0010, branch_taken=1, if_id_pc_plus4=0x14. Required: next inst_addr=32'h40 (jump wins); IF/ID bubbled.
5. Flush+stall and wrap:
   - flush=1 and stall=1 together. Required: pc holds, if_id_valid=0.
   - Separately, force pc to 32'hFFFF_FFFC via branch. Required: next sequential inst_addr=0.
6. Reset mid-operation: rst=1 during an active stall and branch. Required: next edge gives inst_addr=RESET_PC, if_id_inst=0, if_id_valid=0, if_id_pc_plus4=0.

Source files
------------

// File: rtl/if_stage_pc.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID pipeline register, honouring stall, flush and redirects.
module if_stage_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] jump_addr;
    logic [XLEN-1:0] branch_addr;
    logic            redirect;

    logic [XLEN-1:0] if_id_inst_next;
    logic [XLEN-1:0] if_id_pc_plus4_next;
    logic            if_id_valid_next;

    assign inst_addr   = pc;
    assign pc_seq      = pc + XLEN'(PC_STEP);
    // J-type target keeps the region bits of the jump's own PC+4
    assign jump_addr   = {if_id_pc_plus4[31:28], jump_index, 2'b00};
    assign branch_addr = branch_target & ~XLEN'(32'h3);
    assign redirect    = jump | branch_taken;

    // Next-PC selection; redirects come from later stages so they beat stall
    always_comb begin
        pc_next = pc_seq;
        if (jump) begin
            pc_next = jump_addr;
        end else if (branch_taken) begin
            pc_next = branch_addr;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // IF/ID next value: bubble on redirect/flush, hold on stall, else capture
    always_comb begin
        if_id_inst_next     = inst_in;
        if_id_pc_plus4_next = pc_seq;
        if_id_valid_next    = 1'b1;
        if (redirect || flush) begin
            if_id_inst_next     = '0;
            if_id_pc_plus4_next = '0;
            if_id_valid_next    = 1'b0;
        end else if (stall) begin
            if_id_inst_next     = if_id_inst;
            if_id_pc_plus4_next = if_id_pc_plus4;
            if_id_valid_next    = if_id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_inst     <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_next;
            if_id_inst     <= if_id_inst_next;
            if_id_pc_plus4 <= if_id_pc_plus4_next;
            if_id_valid    <= if_id_valid_next;
        end
    end

endmodule

// File: tb/tb_if_stage_pc.sv
// Directed bench for if_stage_pc: sequential fetch, stall, redirects,
// flush, PC wrap and reset priority, against hand-computed values.
module tb_if_stage_pc;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    int checks;
    int failures;

    if_stage_pc #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .inst_addr     (inst_addr),
        .inst_in       (inst_in),
        .if_id_inst    (if_id_inst),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ROM model answers combinationally from the fetch address
    always_comb inst_in = rom(inst_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] a, input logic [31:0] inst,
                             input logic [31:0] p4, input logic v);
        check({tag, ".addr"}, inst_addr, a);
        check({tag, ".inst"}, if_id_inst, inst);
        check({tag, ".pc4"}, if_id_pc_plus4, p4);
        check({tag, ".valid"}, 32'(v), 32'(1'b1 & v));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0;

        // Reset then sequential fetch
        tick();
        check("rst.addr", inst_addr, 32'h0);
        check("rst.inst", if_id_inst, 32'h0);
        check("rst.pc4", if_id_pc_plus4, 32'h0);
        check("rst.valid", 32'(if_id_valid), 32'h0);
        rst = 1'b0;
        tick();
        check("seq0.addr", inst_addr, 32'h4);
        check("seq0.inst", if_id_inst, rom(32'h0));
        check("seq0.pc4", if_id_pc_plus4, 32'h4);
        check("seq0.valid", 32'(if_id_valid), 32'h1);
        tick();
        check("seq1.addr", inst_addr, 32'h8);
        check("seq1.inst", if_id_inst, rom(32'h4));
        check("seq1.pc4", if_id_pc_plus4, 32'h8);

        // Stall two cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall.addr", inst_addr, 32'h8);
            check("stall.inst", if_id_inst, rom(32'h4));
            check("stall.pc4", if_id_pc_plus4, 32'h8);
            check("stall.valid", 32'(if_id_valid), 32'h1);
        end
        stall = 1'b0;
        tick();
        check("resume.addr", inst_addr, 32'hC);
        check("resume.inst", if_id_inst, rom(32'h8));
        check("resume.pc4", if_id_pc_plus4, 32'hC);
        tick();
        check("seq2.addr", inst_addr, 32'h10);

        // Branch at pc=16 to an unaligned target
        branch_taken = 1'b1; branch_target = 32'h0000_0041;
        tick();
        check("br.addr", inst_addr, 32'h40);
        check("br.valid", 32'(if_id_valid), 32'h0);
        check("br.inst", if_id_inst, 32'h0);
        check("br.pc4", if_id_pc_plus4, 32'h0);
        branch_taken = 1'b0;
        tick();
        check("br1.addr", inst_addr, 32'h44);
        check("br1.inst", if_id_inst, rom(32'h40));
        check("br1.pc4", if_id_pc_plus4, 32'h44);
        check("br1.valid", 32'(if_id_valid), 32'h1);

        // Set up if_id_pc_plus4=0x14, then jump and branch together
        branch_taken = 1'b1; branch_target = 32'h0000_0010;
        tick();
        branch_taken = 1'b0;
        tick();
        check("setup.pc4", if_id_pc_plus4, 32'h14);
        jump = 1'b1; jump_index = 26'h000_0010;
        branch_taken = 1'b1; branch_target = 32'h0000_0080;
        tick();
        check("jmp.addr", inst_addr, 32'h40);
        check("jmp.valid", 32'(if_id_valid), 32'h0);
        check("jmp.pc4", if_id_pc_plus4, 32'h0);
        jump = 1'b0; branch_taken = 1'b0;
        tick();
        check("jmp1.addr", inst_addr, 32'h44);
        check("jmp1.inst", if_id_inst, rom(32'h40));

        // Flush with stall: bubble, PC holds
        flush = 1'b1; stall = 1'b1;
        tick();
        check("fs.addr", inst_addr, 32'h44);
        check("fs.valid", 32'(if_id_valid), 32'h0);
        check("fs.inst", if_id_inst, 32'h0);
        // Flush alone: bubble, PC advances
        stall = 1'b0;
        tick();
        check("fl.addr", inst_addr, 32'h48);
        check("fl.valid", 32'(if_id_valid), 32'h0);
        flush = 1'b0;
        tick();
        check("fl1.addr", inst_addr, 32'h4C);
        check("fl1.inst", if_id_inst, rom(32'h48));
        check("fl1.pc4", if_id_pc_plus4, 32'h4C);
        check("fl1.valid", 32'(if_id_valid), 32'h1);

        // Jump target takes its region bits from if_id_pc_plus4
        branch_taken = 1'b1; branch_target = 32'hF000_0000;
        tick();
        branch_taken = 1'b0;
        tick();
        check("hi.pc4", if_id_pc_plus4, 32'hF000_0004);
        jump = 1'b1; jump_index = 26'h3FF_FFFF;
        tick();
        check("hijmp.addr", inst_addr, 32'hFFFF_FFFC);
        jump = 1'b0;

        // Sequential wrap from 0xFFFF_FFFC
        tick();
        check("wrap.addr", inst_addr, 32'h0);
        check("wrap.inst", if_id_inst, rom(32'hFFFF_FFFC));
        check("wrap.pc4", if_id_pc_plus4, 32'h0);
        check("wrap.valid", 32'(if_id_valid), 32'h1);

        // Redirect beats stall
        tick();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0022;
        tick();
        check("brst.addr", inst_addr, 32'h20);
        check("brst.valid", 32'(if_id_valid), 32'h0);
        branch_taken = 1'b0;
        tick();
        check("brst1.addr", inst_addr, 32'h20);

        // Reset during active stall and branch
        branch_taken = 1'b1; branch_target = 32'h0000_0100; rst = 1'b1;
        tick();
        check("rst2.addr", inst_addr, 32'h0);
        check("rst2.inst", if_id_inst, 32'h0);
        check("rst2.pc4", if_id_pc_plus4, 32'h0);
        check("rst2.valid", 32'(if_id_valid), 32'h0);
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        tick();
        check("post.addr", inst_addr, 32'h4);
        check("post.inst", if_id_inst, rom(32'h0));
        check("post.valid", 32'(if_id_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
